game_state_reader: RTL



---
 rtl/game_pkg.sv | 24 ++
 rtl/cell_index_counter.sv | 43 ++++
 rtl/game_state_reader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared Sokoban game-state definitions: board geometry defaults, tile codes and
// the state-reader FSM encoding.
package game_pkg;

  localparam int unsigned GameW  = 8;
  localparam int unsigned GameH  = 8;
  localparam int unsigned GameTB = 2;
  localparam int unsigned GameXW = $clog2(GameW);
  localparam int unsigned GameYW = $clog2(GameH);
  localparam int unsigned GameN  = GameW * GameH * GameTB + GameXW + GameYW;

  localparam logic [1:0] TILE_FLOOR = 2'b00;
  localparam logic [1:0] TILE_WALL  = 2'b01;
  localparam logic [1:0] TILE_BOX   = 2'b10;
  localparam logic [1:0] TILE_GOAL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StSnap,
    StStream,
    StDone
  } reader_state_e;

endpackage

// File: rtl/cell_index_counter.sv
// Raster-order cell index with clear/enable, last-cell flag and x/y split.
module cell_index_counter #(
  parameter int unsigned XW = 3,
  parameter int unsigned YW = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic             last_o,
  output logic [XW+YW-1:0] idx_o,
  output logic [XW+YW-1:0] idx_next_o,
  output logic [XW-1:0]    x_o,
  output logic [YW-1:0]    y_o
);

  logic [XW+YW-1:0] idx_q, idx_d;

  assign idx_next_o = idx_q + 1'b1;
  // Board dimensions are powers of two, so the last cell is the all-ones index.
  assign last_o     = &idx_q;
  assign idx_o      = idx_q;
  assign x_o        = idx_q[XW-1:0];
  assign y_o        = idx_q[XW+YW-1:XW];

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = idx_next_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/game_state_reader.sv
// Snapshots the packed Sokoban state on request and streams it one cell per
// valid/ready transfer in raster order, reporting the box count at the end.
module game_state_reader
  import game_pkg::*;
#(
  parameter int unsigned W  = GameW,
  parameter int unsigned H  = GameH,
  parameter int unsigned XW = $clog2(W),
  parameter int unsigned YW = $clog2(H),
  parameter int unsigned TB = GameTB,
  parameter int unsigned N  = W * H * TB + XW + YW,
  parameter int unsigned CW = $clog2(W * H) + 1
) (
  input  logic          clk,
  input  logic          r,
  input  logic          start,
  input  logic [N-1:0]  state,
  output logic          busy,
  output logic          cell_valid,
  input  logic          cell_ready,
  output logic [XW-1:0] cell_x,
  output logic [YW-1:0] cell_y,
  output logic [TB-1:0] cell_tile,
  output logic          cell_player,
  output logic          done,
  output logic [CW-1:0] box_count
);

  localparam int unsigned IW     = XW + YW;
  localparam int unsigned PosLsb = W * H * TB;

  reader_state_e state_q, state_d;
  logic [N-1:0]  snap_q, snap_d;
  logic [TB-1:0] tile_q, tile_d;
  logic          player_q, player_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] run_q, run_d;
  logic [CW-1:0] box_q, box_d;

  logic          cnt_clr, cnt_en, last;
  logic [IW-1:0] idx, idx_next;
  logic [IW-1:0] ppos;
  logic          xfer, box_hit;

  cell_index_counter #(
    .XW (XW),
    .YW (YW)
  ) u_index (
    .clk_i      (clk),
    .rst_i      (r),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .last_o     (last),
    .idx_o      (idx),
    .idx_next_o (idx_next),
    .x_o        (cell_x),
    .y_o        (cell_y)
  );

  // The index is {y, x}, which matches the packed {py, px} player field.
  assign ppos    = snap_q[PosLsb +: IW];
  assign xfer    = valid_q & cell_ready;
  assign box_hit = (tile_q == TB'(TILE_BOX));

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    tile_d   = tile_q;
    player_d = player_q;
    valid_d  = valid_q;
    run_d    = run_q;
    box_d    = box_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSnap;
          snap_d  = state;
          run_d   = '0;
          box_d   = '0;
          cnt_clr = 1'b1;
        end
      end
      StSnap: begin
        state_d  = StStream;
        tile_d   = snap_q[TB-1:0];
        player_d = (ppos == idx);
      end
      StStream: begin
        // First STREAM cycle only raises valid; cell 0 was loaded in SNAP.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (xfer) begin
          run_d = run_q + CW'(box_hit);
          if (last) begin
            valid_d = 1'b0;
            box_d   = run_q + CW'(box_hit);
            state_d = StDone;
          end else begin
            cnt_en   = 1'b1;
            tile_d   = snap_q[TB*idx_next +: TB];
            player_d = (ppos == idx_next);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q  <= StIdle;
      snap_q   <= '0;
      tile_q   <= '0;
      player_q <= 1'b0;
      valid_q  <= 1'b0;
      run_q    <= '0;
      box_q    <= '0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      tile_q   <= tile_d;
      player_q <= player_d;
      valid_q  <= valid_d;
      run_q    <= run_d;
      box_q    <= box_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign cell_valid  = valid_q;
  assign cell_tile   = tile_q;
  assign cell_player = player_q;
  assign box_count   = box_q;

endmodule
